// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in clk cycles.
// Stall detection flags a signal that stopped toggling.
module clk_period_meter #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    MEAS  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hcap, hcap_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, timeout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hcap_n    = hcap;
    period_n  = period;
    high_n    = high_time;
    valid_n   = 1'b0;
    timeout_n = timeout;
    if (!en) begin
      state_n = ARM;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ARM, STALL: begin
          // First edge only sets the reference; no partial period escapes
          if (rise) begin
            state_n   = MEAS;
            cnt_n     = '0;
            hcap_n    = '0;
            timeout_n = 1'b0;
          end
        end
        MEAS: begin
          if (rise) begin
            period_n = cnt + ONE;
            high_n   = hcap;
            valid_n  = 1'b1;
            cnt_n    = '0;
            hcap_n   = '0;
          end else begin
            if (fall) hcap_n = cnt + ONE;
            if (cnt == LAST) begin
              state_n   = STALL;
              timeout_n = 1'b1;
            end else begin
              cnt_n = cnt + ONE;
            end
          end
        end
        default: begin
          state_n = ARM;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARM;
      cnt       <= '0;
      hcap      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hcap      <= hcap_n;
      period    <= period_n;
      high_time <= high_n;
      valid     <= valid_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter with an event-time
// reference model feeding a scoreboard queue.
module tb_clk_period_meter;

  localparam int CNT_W = 8;
  localparam int TO    = 20;
  localparam int MAXC  = 40000;

  logic             clk;
  logic             rst;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;

  clk_period_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
  } exp_t;

  exp_t q[$];
  bit   samp[0:MAXC-1];
  int   cyc = 0;
  int   base = 0;
  int   refc = 0;
  int   fallc = 0;
  bit   tracking = 0;
  bit   stalled = 0;
  bit   fall_seen = 0;
  bit   exp_valid = 0;
  bit   exp_timeout = 0;
  bit   r, f;
  int   checks = 0;
  int   errors = 0;

  // Sample value seen at edge i; anything before reset counts as low
  function automatic bit s(input int i);
    if (i < base || i < 0) return 1'b0;
    return samp[i];
  endfunction

  // Reference: a level change sampled at edge k is acted on at edge k+2
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      base        = cyc + 1;
      tracking    = 0;
      stalled     = 0;
      fall_seen   = 0;
      exp_valid   = 0;
      exp_timeout = 0;
      q.delete();
    end else begin
      cyc++;
      samp[cyc % MAXC] = sig_in;
      exp_valid = 0;
      r = s(cyc - 2) && !s(cyc - 3);
      f = !s(cyc - 2) && s(cyc - 3);
      if (!en) begin
        tracking = 0;
        stalled  = 0;
      end else if (r) begin
        if (tracking && !stalled) begin
          q.push_back('{cyc - refc, fall_seen ? fallc - refc : 0});
          exp_valid = 1;
        end
        refc        = cyc;
        tracking    = 1;
        stalled     = 0;
        fall_seen   = 0;
        exp_timeout = 0;
      end else if (tracking && !stalled) begin
        if (f) begin
          fall_seen = 1;
          fallc     = cyc;
        end
        if (cyc - refc == TO) begin
          stalled     = 1;
          exp_timeout = 1;
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               name, cyc, got, exp);
    end
  endtask

  exp_t e;

  always @(negedge clk) begin
    check("valid", int'(valid), int'(exp_valid));
    check("timeout", int'(timeout), int'(exp_timeout));
    if (valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("period", int'(period), e.p);
        check("high_time", int'(high_time), e.h);
      end
    end
  end

  task automatic wave(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        #($urandom_range(0, 3));
        sig_in = (i < hi);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sig_in = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high_time), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;

    wave(10, 5, 6);
    wave(8, 4, 6);

    wave(10, 5, 3);
    idle(35);
    check("stall_level", int'(timeout), 1);
    check("stall_period_hold", int'(period), 8 + 2 * 0 + 2);
    wave(10, 5, 3);
    check("stall_cleared", int'(timeout), 0);

    wave(TO, 7, 4);
    check("boundary_no_stall", int'(timeout), 0);
    check("boundary_period", int'(period), TO);

    fork
      wave(10, 5, 6);
      begin
        repeat (23) @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        en = 1'b1;
      end
    join

    fork
      wave(10, 5, 5);
      begin
        repeat (17) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_period", int'(period), 0);
        check("arst_high", int'(high_time), 0);
        check("arst_valid", int'(valid), 0);
        check("arst_timeout", int'(timeout), 0);
        #1 rst = 1'b0;
      end
    join

    for (int it = 0; it < 60; it++) begin
      automatic int per = $urandom_range(3, 30);
      automatic int hi  = $urandom_range(1, per - 1);
      automatic bit drop = ($urandom_range(0, 5) == 0);
      fork
        wave(per, hi, $urandom_range(1, 3));
        if (drop) begin
          repeat ($urandom_range(0, per - 1)) @(negedge clk);
          en = 1'b0;
          repeat ($urandom_range(1, 8)) @(negedge clk);
          en = 1'b1;
        end
      join
    end

    idle(5);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
